// File: rtl/seq_shifter.sv
// Multi-cycle logical/rotate shifter: one power-of-two barrel stage per clock.
// A single shared stage applies 2^k on cycle k, so every op takes exactly CNTW cycles.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; done pulses here for one cycle after SHIFT
// SHIFT | applying stage k (shift by 2^k if cnt_r[k]) on each clock
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [CNTW-1:0]  cnt,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   localparam int            KW     = (CNTW > 1) ? $clog2(CNTW) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(CNTW - 1);

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_SRL = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] stage_res;
   logic [CNTW-1:0]  cnt_r;
   logic [1:0]       op_r;
   logic [KW-1:0]    k;
   logic             accept;
   logic             last;
   int unsigned      sh;

   assign accept = (state == IDLE) && start;
   assign last   = (state == SHIFT) && (k == K_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (k == K_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   // Stage k moves the word by 2^k; rotates wrap the bits shifted out.
   always_comb begin
      sh        = 32'd1 << k;
      stage_res = work;
      if (cnt_r[k]) begin
         case (op_r)
            OP_ROL:  stage_res = (work << sh) | (work >> (WIDTH - sh));
            OP_SLL:  stage_res = work << sh;
            OP_ROR:  stage_res = (work >> sh) | (work << (WIDTH - sh));
            OP_SRL:  stage_res = work >> sh;
            default: stage_res = work;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work  <= '0;
         cnt_r <= '0;
         op_r  <= '0;
         k     <= '0;
         out   <= '0;
         done  <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            work  <= in;
            cnt_r <= cnt;
            op_r  <= op;
            k     <= '0;
         end else if (state == SHIFT) begin
            work <= stage_res;
            k    <= k + KW'(1);
            if (last) out <= stage_res;
         end
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and random checks for seq_shifter (WIDTH=16): latency, done pulse,
// busy-start rejection, back-to-back issue and asynchronous reset abort.
module tb_seq_shifter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] din;
   logic [3:0]  dcnt;
   logic [1:0]  dop;
   logic        busy;
   logic        done;
   logic [15:0] dout;

   int          checks;
   int          failures;
   logic [15:0] exp_out;

   seq_shifter #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in    (din),
      .cnt   (dcnt),
      .op    (dop),
      .busy  (busy),
      .done  (done),
      .out   (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bit-at-a-time reference, deliberately unlike the barrel-stage datapath.
   function automatic logic [15:0] ref_sh(input logic [15:0] a, input logic [3:0] c,
                                          input logic [1:0] o);
      logic [15:0] r;
      r = a;
      for (int i = 0; i < int'(c); i++) begin
         case (o)
            2'b00:   r = {r[14:0], r[15]};
            2'b01:   r = {r[14:0], 1'b0};
            2'b10:   r = {r[0], r[15:1]};
            default: r = {1'b0, r[15:1]};
         endcase
      end
      return r;
   endfunction

   // Called at a negedge; returns just after the accepting edge with inputs scrambled.
   task automatic issue(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o);
      start = 1'b1;
      din   = a;
      dcnt  = c;
      dop   = o;
      @(posedge clk);
      #1;
      start = 1'b0;
      din   = ~a;
      dcnt  = ~c;
      dop   = ~o;
   endtask

   // Four busy cycles, then the done cycle; optionally pokes start while busy.
   task automatic wait_done(input logic [15:0] exp, input bit inject);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("busy_phase", {30'd0, busy, done}, 32'h2);
         check("out_hold", {16'd0, dout}, {16'd0, exp_out});
         if (inject && i == 1) begin
            start = 1'b1;
            din   = 16'h1111;
            dcnt  = 4'd0;
            dop   = 2'b00;
         end
         if (inject && i == 2) start = 1'b0;
      end
      @(negedge clk);
      check("done_phase", {30'd0, busy, done}, 32'h1);
      check("result", {16'd0, dout}, {16'd0, exp});
      exp_out = exp;
   endtask

   task automatic idle_chk();
      @(negedge clk);
      check("done_drop", {30'd0, busy, done}, 32'h0);
      check("out_stable", {16'd0, dout}, {16'd0, exp_out});
   endtask

   task automatic run(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                      input logic [15:0] exp);
      issue(a, c, o);
      wait_done(exp, 1'b0);
      idle_chk();
   endtask

   initial begin
      logic [15:0] ra;
      logic [3:0]  rc;
      logic [1:0]  ro;

      checks   = 0;
      failures = 0;
      exp_out  = 16'h0000;
      rst_n    = 1'b0;
      start    = 1'b0;
      din      = 16'h0000;
      dcnt     = 4'd0;
      dop      = 2'b00;

      #12;
      check("reset_state", {14'd0, busy, done, dout}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(16'hF0F0, 4'd4,  2'b11, 16'h0F0F);
      run(16'h8001, 4'd1,  2'b00, 16'h0003);
      run(16'h1234, 4'd8,  2'b10, 16'h3412);
      run(16'h0001, 4'd15, 2'b01, 16'h8000);
      run(16'h8000, 4'd15, 2'b11, 16'h0001);
      run(16'hBEEF, 4'd0,  2'b00, 16'hBEEF);
      run(16'hBEEF, 4'd0,  2'b01, 16'hBEEF);
      run(16'hBEEF, 4'd0,  2'b10, 16'hBEEF);
      run(16'hBEEF, 4'd0,  2'b11, 16'hBEEF);
      run(16'h8001, 4'd15, 2'b00, 16'hC000);
      run(16'h8001, 4'd15, 2'b10, 16'h0003);

      // Start while busy is ignored; start in the done cycle is accepted.
      issue(16'hFFFF, 4'd8, 2'b11);
      wait_done(16'h00FF, 1'b1);
      issue(16'h00FF, 4'd4, 2'b00);
      wait_done(16'h0FF0, 1'b0);
      idle_chk();

      // Asynchronous reset in the middle of an operation.
      issue(16'h1234, 4'd1, 2'b01);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_reset", {14'd0, busy, done, dout}, 32'h0);
      exp_out = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_abort", {14'd0, busy, done, dout}, 32'h0);
      end
      run(16'h00F0, 4'd4, 2'b01, 16'h0F00);

      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom);
         rc = 4'($urandom_range(15, 0));
         ro = 2'($urandom_range(3, 0));
         run(ra, rc, ro, ref_sh(ra, rc, ro));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Parametrised, multi-cycle logical/rotate shifter that generalises the single fixed-distance right-shift stage into a full shifter.
- Supports any WIDTH, any shift count in 0..WIDTH-1 and four shift modes.
- Applies one power-of-two barrel stage per clock, so one shared stage datapath replaces log2(WIDTH) parallel mux rows.
- Sits beside the ALU as the shift/rotate unit, with a start/done handshake.

Parameters:
- WIDTH, 16: data width in bits; must be a power of two, >= 2.
- CNTW, $clog2(WIDTH) (4): count width and number of shift stages; derived, never overridden independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk; accepted only when busy=0.
- in  input  WIDTH  operand, latched on accepted start.
- cnt  input  CNTW  shift distance, latched on accepted start.
- op  input  2  mode, latched on accepted start: 00 ROL, 01 SLL, 10 ROR, 11 SRL.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out is updated.
- out  output  WIDTH  result register; holds the last result until the next completion.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, out=0, internal work/count/op/stage registers = 0. Reset mid-operation abandons the op: no done pulse, out=0.
- States: IDLE, SHIFT.
  - IDLE: done is 1 only in the first IDLE cycle after SHIFT completes, else 0. On start=1: latch work<=in, cnt_r<=cnt, op_r<=op, k<=0, go to SHIFT, busy<=1.
  - SHIFT, each cycle with stage index k:
    - If cnt_r[k]=1, shift work by 2^k per op_r; otherwise work is unchanged.
    - SLL/SRL fill vacated bits with 0. ROL/ROR wrap the bits shifted out into the vacated positions.
    - k<=k+1.
    - When k=CNTW-1: out<=stage result, done<=1, busy<=0, go to IDLE.
- Latency: start accepted on edge E0; out valid and done=1 in the cycle after edge E_CNTW, i.e. exactly CNTW cycles after acceptance (4 for WIDTH=16). Latency is fixed and independent of cnt, including cnt=0.
- start while busy=1: ignored; latched operands are unaffected.
- start during the done cycle: accepted, since the state is IDLE. This gives back-to-back throughput of one op per CNTW cycles.
- Inputs (in, cnt, op) may change freely after acceptance.
- out changes only on completion or reset. done is never high while busy is high.
- No arithmetic shift. cnt cannot exceed WIDTH-1 by construction.

Test Plan:
- WIDTH=16, op=11 (SRL), in=0xF0F0, cnt=4, start pulse: busy high 4 cycles, then done=1 for exactly one cycle with out=0x0F0F.
- op=00 (ROL), in=0x8001, cnt=1 -> out=0x0003. op=10 (ROR), in=0x1234, cnt=8 -> out=0x3412.
- op=01 (SLL), in=0x0001, cnt=15 -> out=0x8000. op=11 (SRL), in=0x8000, cnt=15 -> out=0x0001. cnt=0, in=0xBEEF, any op -> out=0xBEEF after 4 cycles.
- Start SRL in=0xFFFF cnt=8. Pulse start with in=0x1111 on cycle 2 -> out=0x00FF, no extra done. Then assert start with ROL in=0x00FF cnt=4 in the done cycle -> accepted, second done 4 cycles later with out=0x0FF0.
- Start op, drive rst_n low asynchronously mid-cycle 2 -> busy=0, done=0, out=0 immediately; no done pulse after release. Next op completes normally.
- Random regression: 1000 random {in, cnt, op} against a reference model. Check fixed 4-cycle latency, a single-cycle done, and that out is stable between completions.
